// File: rtl/sd_arb_pkg.sv
// Shared types and default sizing for the SDRAM read/write arbiter.
package sd_arb_pkg;

  localparam int unsigned ADDR_W_DEFAULT          = 24;
  localparam int unsigned DATA_W_DEFAULT          = 32;
  localparam int unsigned MAX_OUTSTANDING_DEFAULT = 8;

  // Command slot contents
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  // Which requester was granted most recently
  typedef enum logic {
    G_RD = 1'b0,
    G_WR = 1'b1
  } grant_e;

endpackage

// File: rtl/sd_credit_counter.sv
// Outstanding-read tracker: up/down counter with credit compare and sticky underflow.
module sd_credit_counter #(
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned CNT_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             pending,
  output logic [CNT_W-1:0] count,
  output logic             credit,
  output logic             underflow
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic [CNT_W:0]   committed;

  // Next count; a return with nothing outstanding is flagged and not counted
  always_comb begin
    count_d     = count_q;
    underflow_d = underflow_q;
    if (dec && (count_q == '0)) begin
      underflow_d = 1'b1;
    end else if (inc && !dec) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter and sticky flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // A read sitting in the slot already consumes a credit, accepted or not
  always_comb begin
    committed = {1'b0, count_q} + {{CNT_W{1'b0}}, pending};
    credit    = committed < (CNT_W + 1)'(MAX_OUTSTANDING);
  end

  assign count     = count_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/sd_rw_arbiter.sv
// Round-robin arbiter sharing one SDRAM Avalon-MM master between a read and a write requester.
module sd_rw_arbiter
  import sd_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W          = DATA_W_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter int unsigned CNT_W           = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req_valid,
  input  logic [ADDR_W-1:0] rd_req_addr,
  output logic              rd_req_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              wr_req_valid,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              wr_req_ready,
  output logic [ADDR_W-1:0] av_address,
  output logic              av_read,
  output logic              av_write,
  output logic [DATA_W-1:0] av_writedata,
  input  logic              av_waitrequest,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_readdatavalid,
  output logic [CNT_W-1:0]  outstanding,
  output logic              busy,
  output logic              err_underflow
);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  grant_e            grant;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_data_valid_q;
  logic              accept, slot_free, credit, rd_elig, wr_elig, load;

  assign accept    = (state_q != IDLE) && !av_waitrequest;
  assign slot_free = (state_q == IDLE) || accept;
  assign rd_elig   = rd_req_valid && credit;
  assign wr_elig   = wr_req_valid;
  assign load      = slot_free && (rd_elig || wr_elig) && !reset;

  sd_credit_counter #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .CNT_W           (CNT_W)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .inc       ((state_q == RD) && accept),
    .dec       (av_readdatavalid),
    .pending   (state_q == RD),
    .count     (outstanding),
    .credit    (credit),
    .underflow (err_underflow)
  );

  // State and round-robin pointer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= G_WR;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grant selection and next slot contents; slot refills in the cycle it frees
  always_comb begin
    if (rd_elig && wr_elig) begin
      grant = (last_grant_q == G_WR) ? G_RD : G_WR;
    end else if (rd_elig) begin
      grant = G_RD;
    end else begin
      grant = G_WR;
    end
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (load) begin
      state_d      = (grant == G_RD) ? RD : WR;
      last_grant_d = grant;
    end else if (slot_free) begin
      state_d = IDLE;
    end
  end

  // Strobes, handshakes and status decoded from the slot
  always_comb begin
    av_read      = (state_q == RD);
    av_write     = (state_q == WR);
    rd_req_ready = load && (grant == G_RD);
    wr_req_ready = load && (grant == G_WR);
    busy         = (state_q != IDLE) || (outstanding != '0);
  end

  // Command address/data captured on load, held through waitrequest
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load) begin
      if (grant == G_RD) begin
        addr_q <= rd_req_addr;
      end else begin
        addr_q  <= wr_req_addr;
        wdata_q <= wr_req_data;
      end
    end
  end

  // Read return pipeline: forwarded in order, no backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      rd_data_valid_q <= av_readdatavalid;
      if (av_readdatavalid) begin
        rd_data_q <= av_readdata;
      end
    end
  end

  assign av_address    = addr_q;
  assign av_writedata  = wdata_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;

endmodule

// File: tb/tb_sd_rw_arbiter.sv
// Directed bench for sd_rw_arbiter: contention, waitrequest hold, credit limit, reset mid-burst.
module tb_sd_rw_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req_valid;
  logic [23:0] rd_req_addr;
  logic        rd_req_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic        wr_req_valid;
  logic [23:0] wr_req_addr;
  logic [31:0] wr_req_data;
  logic        wr_req_ready;
  logic [23:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;
  logic [3:0]  outstanding;
  logic        busy;
  logic        err_underflow;

  int passed = 0;
  int total  = 0;
  int n;

  always #5 clk = ~clk;

  sd_rw_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .rd_req_valid     (rd_req_valid),
    .rd_req_addr      (rd_req_addr),
    .rd_req_ready     (rd_req_ready),
    .rd_data          (rd_data),
    .rd_data_valid    (rd_data_valid),
    .wr_req_valid     (wr_req_valid),
    .wr_req_addr      (wr_req_addr),
    .wr_req_data      (wr_req_data),
    .wr_req_ready     (wr_req_ready),
    .av_address       (av_address),
    .av_read          (av_read),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_waitrequest   (av_waitrequest),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .outstanding      (outstanding),
    .busy             (busy),
    .err_underflow    (err_underflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    rd_req_valid = 1'b0; rd_req_addr = '0;
    wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
    av_waitrequest = 1'b0; av_readdata = '0; av_readdatavalid = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_av_read", 64'(av_read), 0);
    chk("rst_av_write", 64'(av_write), 0);
    chk("rst_av_address", 64'(av_address), 0);
    chk("rst_av_writedata", 64'(av_writedata), 0);
    chk("rst_rd_data_valid", 64'(rd_data_valid), 0);
    chk("rst_outstanding", 64'(outstanding), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_err", 64'(err_underflow), 0);
    reset = 1'b0;

    // Contention: first contest after reset goes to RD, then alternates
    rd_req_valid = 1'b1; rd_req_addr = 24'h000100;
    wr_req_valid = 1'b1; wr_req_addr = 24'h000200; wr_req_data = 32'h000000A5;
    #1;
    chk("ct0_rd_ready", 64'(rd_req_ready), 1);
    chk("ct0_wr_ready", 64'(wr_req_ready), 0);
    tick();
    chk("ct1_av_read", 64'(av_read), 1);
    chk("ct1_av_write", 64'(av_write), 0);
    chk("ct1_addr", 64'(av_address), 64'h100);
    chk("ct1_rd_ready", 64'(rd_req_ready), 0);
    chk("ct1_wr_ready", 64'(wr_req_ready), 1);
    tick();
    chk("ct2_av_write", 64'(av_write), 1);
    chk("ct2_av_read", 64'(av_read), 0);
    chk("ct2_addr", 64'(av_address), 64'h200);
    chk("ct2_wdata", 64'(av_writedata), 64'hA5);
    chk("ct2_outstanding", 64'(outstanding), 1);
    chk("ct2_rd_ready", 64'(rd_req_ready), 1);
    tick();
    chk("ct3_av_read", 64'(av_read), 1);
    rd_req_valid = 1'b0; wr_req_valid = 1'b0;
    #1;
    chk("ct3_rd_ready_idle", 64'(rd_req_ready), 0);
    tick();
    chk("ct4_av_read", 64'(av_read), 0);
    chk("ct4_outstanding", 64'(outstanding), 2);
    chk("ct4_busy", 64'(busy), 1);
    av_readdatavalid = 1'b1; av_readdata = 32'h11;
    tick();
    chk("ret0_valid", 64'(rd_data_valid), 1);
    chk("ret0_data", 64'(rd_data), 64'h11);
    chk("ret0_outstanding", 64'(outstanding), 1);
    av_readdata = 32'h22;
    tick();
    chk("ret1_data", 64'(rd_data), 64'h22);
    chk("ret1_outstanding", 64'(outstanding), 0);
    chk("ret1_busy", 64'(busy), 0);
    av_readdatavalid = 1'b0;
    tick();
    chk("ret2_valid", 64'(rd_data_valid), 0);

    // Waitrequest hold on a write
    wr_req_valid = 1'b1; wr_req_addr = 24'h002000; wr_req_data = 32'hDEADBEEF;
    av_waitrequest = 1'b1;
    #1;
    chk("wh_ready_load", 64'(wr_req_ready), 1);
    tick();
    wr_req_addr = 24'h003000; wr_req_data = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wh_ready_held", 64'(wr_req_ready), 0);
      chk("wh_av_write", 64'(av_write), 1);
      chk("wh_addr", 64'(av_address), 64'h2000);
      chk("wh_data", 64'(av_writedata), 64'hDEADBEEF);
      tick();
    end
    av_waitrequest = 1'b0;
    #1;
    chk("wh_release_ready", 64'(wr_req_ready), 1);
    tick();
    chk("wh_next_addr", 64'(av_address), 64'h3000);
    chk("wh_next_data", 64'(av_writedata), 64'h12345678);
    chk("wh_next_write", 64'(av_write), 1);
    wr_req_valid = 1'b0;
    tick();
    chk("wh_idle_write", 64'(av_write), 0);

    // Credit limit: no returns, only 8 reads accepted
    rd_req_valid = 1'b1; rd_req_addr = 24'h000400;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (rd_req_ready) begin
        n++;
        rd_req_addr = rd_req_addr + 24'd4;
      end
      tick();
    end
    chk("cl_accepted", 64'(n), 8);
    chk("cl_outstanding", 64'(outstanding), 8);
    chk("cl_av_read", 64'(av_read), 0);
    chk("cl_rd_ready", 64'(rd_req_ready), 0);
    av_readdatavalid = 1'b1; av_readdata = 32'h33;
    #1;
    chk("cl_no_credit", 64'(rd_req_ready), 0);
    tick();
    av_readdatavalid = 1'b0;
    chk("cl_after_ret", 64'(outstanding), 7);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (rd_req_ready) n++;
      tick();
    end
    chk("cl_one_more", 64'(n), 1);
    chk("cl_refull", 64'(outstanding), 8);

    // Drain to 3, then read accept and return in the same cycle
    rd_req_valid = 1'b0;
    av_readdatavalid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    av_readdatavalid = 1'b0;
    chk("sim_pre", 64'(outstanding), 3);
    rd_req_valid = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    av_readdatavalid = 1'b1;
    tick();
    av_readdatavalid = 1'b0;
    chk("sim_outstanding", 64'(outstanding), 3);
    chk("sim_av_read", 64'(av_read), 0);

    // Two more reads to reach 5, then reset with a read stalled
    rd_req_valid = 1'b1;
    tick(); tick();
    rd_req_valid = 1'b0;
    tick();
    chk("mb_outstanding", 64'(outstanding), 5);
    rd_req_valid = 1'b1; av_waitrequest = 1'b1;
    tick();
    rd_req_valid = 1'b0;
    chk("mb_stalled_read", 64'(av_read), 1);
    reset = 1'b1;
    tick();
    chk("mb_rst_read", 64'(av_read), 0);
    chk("mb_rst_outstanding", 64'(outstanding), 0);
    reset = 1'b0; av_waitrequest = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      av_readdatavalid = 1'b1; av_readdata = 32'h50 + 32'(i);
      tick();
      if (rd_data_valid) n++;
      chk("mb_cnt_zero", 64'(outstanding), 0);
      chk("mb_data", 64'(rd_data), 64'h50 + 64'(i));
    end
    av_readdatavalid = 1'b0;
    tick();
    chk("mb_pulses", 64'(n), 5);
    chk("mb_err", 64'(err_underflow), 1);
    tick();
    chk("mb_err_sticky", 64'(err_underflow), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sd_rw_arbiter.md
Name: sd_rw_arbiter

Overview:
Scheduler that shares the single SDRAM Avalon-MM master port between the notch filter's sample-read requester and its result-write requester. It replaces ad-hoc sdread/sdwrite interlocking with one arbitrated command slot and round-robin grant. It also tracks outstanding reads against a credit limit and returns read data in order to the read requester. It sits between the filter's request/write FIFOs and the SDRAM master interface.

Parameters:
ADDR_W, 24, byte address width of SDRAM master
DATA_W, 32, data width
MAX_OUTSTANDING, 8, maximum accepted-but-unreturned reads (power of two, >=2)
CNT_W, 4, width of outstanding counter (log2(MAX_OUTSTANDING)+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
rd_req_valid  in  1  read requester has an address
rd_req_addr  in  ADDR_W  read byte address
rd_req_ready  out  1  read request taken this cycle
rd_data  out  DATA_W  returned read data
rd_data_valid  out  1  rd_data valid, one pulse per word
wr_req_valid  in  1  write requester has address+data
wr_req_addr  in  ADDR_W  write byte address
wr_req_data  in  DATA_W  write data
wr_req_ready  out  1  write request taken this cycle
av_address  out  ADDR_W  Avalon address
av_read  out  1  Avalon read
av_write  out  1  Avalon write
av_writedata  out  DATA_W  Avalon write data
av_waitrequest  in  1  Avalon waitrequest
av_readdata  in  DATA_W  Avalon read data
av_readdatavalid  in  1  Avalon read data valid
outstanding  out  CNT_W  current outstanding read count
busy  out  1  command slot occupied or outstanding != 0
err_underflow  out  1  sticky: readdatavalid with outstanding==0

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset values: av_read=0, av_write=0, av_address=0, av_writedata=0, rd_data_valid=0, rd_data=0, rd_req_ready=0, wr_req_ready=0, outstanding=0, err_underflow=0, last_grant=WR (so first contest goes to RD).
- Single registered command slot; states IDLE (slot empty), RD (av_read=1), WR (av_write=1). av_read and av_write are never both high.
- Command accepted when (av_read|av_write) && !av_waitrequest. Address, data and strobe are held stable while waitrequest=1.
- Slot loadable in a cycle when state==IDLE or the current command is accepted that cycle (back-to-back issue, no bubble).
- RD eligible: rd_req_valid && credit, where credit = (outstanding + (state==RD ? 1 : 0)) < MAX_OUTSTANDING. An accepted read this cycle still counts.
- WR eligible: wr_req_valid. Writes are never credit-limited and may issue while reads are outstanding.
- Grant: if both eligible, grant the opposite of last_grant; otherwise grant the eligible one. On load, update last_grant and pulse the matching *_req_ready for exactly that cycle. Requester input is sampled in that same cycle, and av_* shows it on the next cycle (1-cycle issue latency).
- If no eligible requester when the slot frees: return to IDLE, strobes low the next cycle.
- Outstanding: +1 on read accept, -1 on av_readdatavalid. Both in the same cycle: unchanged.
- Read return: rd_data/rd_data_valid are av_readdata/av_readdatavalid registered (1-cycle latency), in order, unconditional (no backpressure). The consumer must have space for `outstanding` words.
- av_readdatavalid with outstanding==0 (e.g. after mid-burst reset): data is still forwarded, counter stays 0, err_underflow is set. err_underflow clears only on reset.
- Reset mid-operation: strobes drop the next cycle, even when waitrequest=1. The pending command is abandoned.
- busy = (state!=IDLE) || (outstanding!=0).

Decomposition:
- Package sd_arb_pkg: state enum {IDLE, RD, WR}, grant enum {G_RD, G_WR}, default ADDR_W/DATA_W/MAX_OUTSTANDING constants.
- Sub-module sd_credit_counter: up/down counter with limit compare, simultaneous inc/dec and underflow flag.

Test Plan:
- Read stream: rd_req_valid held with addrs 0x100,0x104,...; waitrequest=0; slave returns 3 cycles later -> av_read continuous, outstanding peaks at 4, rd_data in order 0x100-tagged values, no bubbles.
- Credit limit: slave never asserts readdatavalid, 10 reads requested -> exactly 8 accepted, av_read low, rd_req_ready low. One readdatavalid -> exactly one more read issued.
- Contention: rd and wr valid every cycle -> av commands alternate RD,WR,RD,WR starting with RD after reset. Each *_req_ready pulses once per issued command.
- Waitrequest hold: av_write of 0x2000/0xDEADBEEF with waitrequest=1 for 5 cycles -> address/data stable all 5 cycles, wr_req_ready not re-pulsed, next command issues the cycle after release.
- Simultaneous: read accept and readdatavalid in the same cycle with outstanding=3 -> outstanding stays 3.
- Reset mid-burst: reset with outstanding=5, then 5 readdatavalids -> counter 0 throughout, err_underflow=1, rd_data_valid pulses 5 times.
